vga_sync_monitor: RTL

//  Receiver-side checker for the VGA output interface. It samples the HS, VS, BLANK_N and RGB

---
 rtl/vga_sync_monitor_if.sv | 18 +
 rtl/vga_sync_monitor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor_if.sv
// VGA pin bundle as seen at the connector: syncs, blanking and 8-bit colour.
//   hs       horizontal sync, active low
//   vs       vertical sync, active low
//   blank_n  1 = active pixel
//   r, g, b  pixel colour, 8 bits each
// master: the side that drives the pins (controller or stimulus).
// slave:  the side that only observes them (the sync monitor).
interface vga_sync_monitor_if;
    logic       hs;
    logic       vs;
    logic       blank_n;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;

    modport master (output hs, output vs, output blank_n, output r, output g, output b);
    modport slave  (input  hs, input  vs, input  blank_n, input  r, input  g, input  b);
endinterface

// File: rtl/vga_sync_monitor.sv
// Receiver-side checker for a VGA output. Samples the pins once per pixel clock, rebuilds
// line/frame timing from the sync edges, checks it against the nominal mode, and reports
// lock, sticky error flags and a per-frame pixel checksum.
//
// Ports:
//   clk          pixel clock, all logic on posedge
//   reset        synchronous, active high; wins over everything else
//   vga          VGA pins (slave modport): hs, vs, blank_n, r, g, b
//   err_clear    1-cycle pulse, zeroes err_flags (an error raised the same cycle still sets)
//   locked       timing verified on the last complete frame
//   frame_done   1-cycle pulse per completed frame while measuring or locked
//   frame_count  completed frames, wraps
//   h_total_o    last measured line length, clocks
//   v_total_o    last measured frame length, lines
//   frame_sum    sum of r+g+b over the active pixels of the last frame
//   err_flags    sticky: [0] line length [1] hsync width [2] active width
//                        [3] frame length [4] vsync width [5] active lines / timeout
module vga_sync_monitor #(
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned V_TOTAL  = 525,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_SYNC   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    vga_sync_monitor_if.slave        vga,
    input  logic                     err_clear,
    output logic                     locked,
    output logic                     frame_done,
    output logic [15:0]              frame_count,
    output logic [11:0]              h_total_o,
    output logic [11:0]              v_total_o,
    output logic [31:0]              frame_sum,
    output logic [5:0]               err_flags
);

    localparam logic [11:0] HTotal   = 12'(H_TOTAL);
    localparam logic [11:0] HActive  = 12'(H_ACTIVE);
    localparam logic [11:0] HSync    = 12'(H_SYNC);
    localparam logic [11:0] VTotal   = 12'(V_TOTAL);
    localparam logic [11:0] VActive  = 12'(V_ACTIVE);
    localparam logic [11:0] VSync    = 12'(V_SYNC);
    localparam logic [11:0] HTimeout = 12'(2 * H_TOTAL);
    localparam logic [11:0] VTimeout = 12'(2 * V_TOTAL);

    typedef enum logic [1:0] {StIdle, StMeasure, StLocked} state_e;

    // All timing counters saturate rather than wrap so a dead input cannot alias a good value.
    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    state_e      state_q, state_d;
    logic        hs_q, vs_q;
    logic [11:0] hcnt_q, hcnt_d;
    logic [11:0] hs_low_q, hs_low_d;
    logic [11:0] act_cnt_q, act_cnt_d;
    logic [11:0] line_cnt_q, line_cnt_d;
    logic [11:0] vs_lines_q, vs_lines_d;
    logic [11:0] act_lines_q, act_lines_d;
    logic [31:0] pix_sum_q, pix_sum_d;
    logic        line_ok_q, line_ok_d;
    logic        frame_err_q, frame_err_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [11:0] h_total_q, h_total_d;
    logic [11:0] v_total_q, v_total_d;
    logic [31:0] frame_sum_q, frame_sum_d;
    logic [5:0]  err_flags_q, err_flags_d;

    logic        hs_fall, hs_rise, vs_fall, vs_rise;
    logic        checking, timeout, err_seen, state_changed, frame_evt, line_has_act;
    logic [11:0] line_len, line_cnt_eff, act_lines_eff;
    logic [31:0] pix_add;
    logic [5:0]  err_new;

    assign hs_fall = hs_q & ~vga.hs;
    assign hs_rise = ~hs_q & vga.hs;
    assign vs_fall = vs_q & ~vga.vs;
    assign vs_rise = ~vs_q & vga.vs;

    assign checking      = (state_q != StIdle);
    assign line_len      = sat_inc(hcnt_q);
    assign line_has_act  = (act_cnt_q != 12'd0);
    // A same-cycle hs_fall closes a line that still belongs to the frame vs_fall is closing.
    assign line_cnt_eff  = hs_fall ? sat_inc(line_cnt_q) : line_cnt_q;
    assign act_lines_eff = (hs_fall && line_has_act) ? sat_inc(act_lines_q) : act_lines_q;
    assign timeout       = checking && ((hcnt_q >= HTimeout) || (line_cnt_q >= VTimeout));
    assign err_seen      = frame_err_q | (|err_new);
    assign state_changed = (state_d != state_q);
    assign frame_evt     = vs_fall && checking && !timeout;

    // Timing checks; nothing is flagged while idle.
    always_comb begin
        err_new = '0;
        if (checking) begin
            if (hs_fall && line_ok_q && (line_len != HTotal)) err_new[0] = 1'b1;
            if (hs_rise && (hs_low_q != HSync))               err_new[1] = 1'b1;
            if (hs_fall && line_has_act && (act_cnt_q != HActive)) err_new[2] = 1'b1;
            if (vs_fall && (line_cnt_eff != VTotal))          err_new[3] = 1'b1;
            if (vs_rise && (vs_lines_q != VSync))             err_new[4] = 1'b1;
            if ((vs_fall && (act_lines_eff != VActive)) || timeout) err_new[5] = 1'b1;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (vs_fall) state_d = StMeasure;
            end
            StMeasure: begin
                if (timeout)                   state_d = StIdle;
                else if (vs_fall && !err_seen) state_d = StLocked;
            end
            StLocked: begin
                if (timeout)                  state_d = StIdle;
                else if (vs_fall && err_seen) state_d = StMeasure;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        locked = (state_q == StLocked);
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Measurement datapath next-state.
    always_comb begin
        pix_add = vga.blank_n ? ({24'd0, vga.r} + {24'd0, vga.g} + {24'd0, vga.b}) : 32'd0;

        hcnt_d = hs_fall ? 12'd0 : sat_inc(hcnt_q);

        hs_low_d = hs_low_q;
        if (hs_rise)      hs_low_d = 12'd0;
        else if (!vga.hs) hs_low_d = sat_inc(hs_low_q);

        // A blank_n-high clock on the hs_fall cycle is the first pixel of the new line.
        act_cnt_d = hs_fall ? 12'd0 : act_cnt_q;
        if (vga.blank_n) act_cnt_d = sat_inc(act_cnt_d);

        line_cnt_d  = vs_fall ? 12'd0 : line_cnt_eff;
        act_lines_d = vs_fall ? 12'd0 : act_lines_eff;
        pix_sum_d   = (vs_fall ? 32'd0 : pix_sum_q) + pix_add;

        vs_lines_d = vs_fall ? 12'd0 : vs_lines_q;
        if (vs_rise)                 vs_lines_d = 12'd0;
        else if (hs_fall && !vga.vs) vs_lines_d = sat_inc(vs_lines_d);

        // The hs_fall that coincides with a state change starts a fully observed line,
        // so the next line can already be checked.
        line_ok_d   = state_changed ? hs_fall : (line_ok_q | hs_fall);
        // The per-frame error bit ignores err_clear so clearing flags cannot fake a lock.
        frame_err_d = (vs_fall || state_changed) ? 1'b0 : err_seen;

        frame_done_d  = frame_evt;
        frame_count_d = frame_evt ? frame_count_q + 16'd1 : frame_count_q;
        frame_sum_d   = frame_evt ? pix_sum_q : frame_sum_q;
        h_total_d     = (hs_fall && line_ok_q) ? line_len : h_total_q;
        v_total_d     = vs_fall ? line_cnt_eff : v_total_q;
        err_flags_d   = (err_clear ? 6'd0 : err_flags_q) | err_new;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            hcnt_q        <= '0;
            hs_low_q      <= '0;
            act_cnt_q     <= '0;
            line_cnt_q    <= '0;
            vs_lines_q    <= '0;
            act_lines_q   <= '0;
            pix_sum_q     <= '0;
            line_ok_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            h_total_q     <= '0;
            v_total_q     <= '0;
            frame_sum_q   <= '0;
            err_flags_q   <= '0;
        end else begin
            hs_q          <= vga.hs;
            vs_q          <= vga.vs;
            hcnt_q        <= hcnt_d;
            hs_low_q      <= hs_low_d;
            act_cnt_q     <= act_cnt_d;
            line_cnt_q    <= line_cnt_d;
            vs_lines_q    <= vs_lines_d;
            act_lines_q   <= act_lines_d;
            pix_sum_q     <= pix_sum_d;
            line_ok_q     <= line_ok_d;
            frame_err_q   <= frame_err_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            h_total_q     <= h_total_d;
            v_total_q     <= v_total_d;
            frame_sum_q   <= frame_sum_d;
            err_flags_q   <= err_flags_d;
        end
    end

    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign h_total_o   = h_total_q;
    assign v_total_o   = v_total_q;
    assign frame_sum   = frame_sum_q;
    assign err_flags   = err_flags_q;

endmodule
